pipe_ctrl: RTL and testbench

Central pipeline controller: generates the per-stage `hold_flag`/`flush_flag` signals consumed by the pipeline registers (PC, IF/ID, ID/EX, EX/MEM), plus the PC redirect for taken jumps. Arbitrates bus wait, multi-cycle divide, jump and load-use hazards. Tracks divide completion with a timeout watchdog and counts stall cycles.

---
 rtl/pipe_ctrl.sv | 137 +++++++++++++
 tb/tb_pipe_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- central pipeline hazard controller.
//
// Produces per-stage hold/flush flags for the PC, IF/ID, ID/EX and EX/MEM
// pipeline registers. It arbitrates between bus wait, a multi-cycle divide,
// taken jumps and load-use hazards. It drives the PC redirect for jumps,
// watches the divide with a timeout, and counts stalled cycles.
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   bus_wait_i    memory not ready (level)
//   div_start_i   divide in EX, first cycle
//   div_done_i    divider result valid
//   jump_req_i    taken branch/jump resolved in EX
//   jump_addr_i   jump target
//   load_use_i    ID-stage load-use hazard
//   hold_o[3:0]   hold flags: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM
//   flush_o[3:0]  flush flags, same indexing (bit0 never set)
//   pc_we_o       load PC with pc_new_o
//   pc_new_o      redirect target (zero when pc_we_o is low)
//   busy_o        controller is waiting on the divider
//   div_err_o     one-cycle divide timeout pulse
//   stall_cnt_o   saturating count of cycles with hold_o[0] set
module pipe_ctrl #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DIV_TIMEOUT = 64,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  bus_wait_i,
   input  logic                  div_start_i,
   input  logic                  div_done_i,
   input  logic                  jump_req_i,
   input  logic [ADDR_WIDTH-1:0] jump_addr_i,
   input  logic                  load_use_i,
   output logic [3:0]            hold_o,
   output logic [3:0]            flush_o,
   output logic                  pc_we_o,
   output logic [ADDR_WIDTH-1:0] pc_new_o,
   output logic                  busy_o,
   output logic                  div_err_o,
   output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

   localparam int DCW = $clog2(DIV_TIMEOUT);
   localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV_TIMEOUT - 1);

   typedef enum logic {
      S_IDLE     = 1'b0,
      S_DIV_WAIT = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [DCW-1:0]       div_cnt_q, div_cnt_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         div_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      hold_o    = 4'b0000;
      flush_o   = 4'b0000;
      pc_we_o   = 1'b0;
      div_err_o = 1'b0;
      state_d   = state_q;
      div_cnt_d = div_cnt_q;

      // Reset forces every combinational output to its idle value.
      if (!rst) begin
         unique case (state_q)
            S_IDLE: begin
               if (bus_wait_i) begin
                  // Whole pipe frozen; a pending jump stays in EX and re-presents.
                  hold_o = 4'b1111;
               end else if (div_start_i) begin
                  // Freeze the front end, bubble into MEM while the divider runs.
                  hold_o    = 4'b0111;
                  flush_o   = 4'b1000;
                  state_d   = S_DIV_WAIT;
                  div_cnt_d = '0;
               end else if (jump_req_i) begin
                  pc_we_o = 1'b1;
                  flush_o = 4'b0110;
               end else if (load_use_i) begin
                  hold_o  = 4'b0011;
                  flush_o = 4'b0100;
               end
            end

            S_DIV_WAIT: begin
               if (bus_wait_i) begin
                  // A done seen here is left pending; the divider holds its result.
                  hold_o = 4'b1111;
                  if (div_cnt_q != DIV_LAST) begin
                     div_cnt_d = div_cnt_q + 1'b1;
                  end
               end else if (div_done_i) begin
                  state_d = S_IDLE;
               end else if (div_cnt_q == DIV_LAST) begin
                  div_err_o = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  hold_o    = 4'b0111;
                  flush_o   = 4'b1000;
                  div_cnt_d = div_cnt_q + 1'b1;
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (hold_o[0] && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   assign pc_new_o    = pc_we_o ? jump_addr_i : '0;
   assign busy_o      = !rst && (state_q == S_DIV_WAIT);
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

   localparam int AW = 32;
   localparam int T  = 8;
   localparam int CW = 8;
   localparam int SMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          bw, ds, dd, jr, lu;
   logic [AW-1:0] ja;
   logic [3:0]    hold_o, flush_o;
   logic          pc_we_o, busy_o, div_err_o;
   logic [AW-1:0] pc_new_o;
   logic [CW-1:0] stall_cnt_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(.ADDR_WIDTH(AW), .DIV_TIMEOUT(T), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst),
      .bus_wait_i(bw), .div_start_i(ds), .div_done_i(dd),
      .jump_req_i(jr), .jump_addr_i(ja), .load_use_i(lu),
      .hold_o(hold_o), .flush_o(flush_o), .pc_we_o(pc_we_o), .pc_new_o(pc_new_o),
      .busy_o(busy_o), .div_err_o(div_err_o), .stall_cnt_o(stall_cnt_o)
   );

   // Reference model: "in a divide" flag, number of divide-wait cycles
   // already spent, and an integer stall tally.
   bit m_div;
   int m_elapsed;
   int m_stalls;

   function automatic void model_comb(output logic [3:0] eh, output logic [3:0] ef,
                                      output logic ewe, output logic eerr, output bit nd);
      eh = 4'h0; ef = 4'h0; ewe = 1'b0; eerr = 1'b0; nd = m_div;
      if (rst) begin
         nd = 1'b0;
      end else if (!m_div) begin
         if (bw)      eh = 4'hF;
         else if (ds) begin eh = 4'h7; ef = 4'h8; nd = 1'b1; end
         else if (jr) begin ewe = 1'b1; ef = 4'h6; end
         else if (lu) begin eh = 4'h3; ef = 4'h4; end
      end else begin
         if (bw)                      eh = 4'hF;
         else if (dd)                 nd = 1'b0;
         else if (m_elapsed >= T - 1) begin eerr = 1'b1; nd = 1'b0; end
         else begin eh = 4'h7; ef = 4'h8; end
      end
   endfunction

   always @(posedge clk) begin
      logic [3:0] eh, ef;
      logic       ewe, eerr;
      bit         nd;
      model_comb(eh, ef, ewe, eerr, nd);
      if (rst) begin
         m_div = 1'b0; m_elapsed = 0; m_stalls = 0;
      end else begin
         if (eh[0] && m_stalls < SMAX) m_stalls++;
         if (m_div && nd) m_elapsed++;
         else             m_elapsed = 0;
         m_div = nd;
      end
   end

   task automatic set_in(input logic b, input logic s, input logic d,
                         input logic j, input logic l);
      bw = b; ds = s; dd = d; jr = j; lu = l; ja = $urandom;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(1, 1, 1, 1, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({hold_o, flush_o, pc_we_o, busy_o, div_err_o} !== 11'h0 || pc_new_o !== '0 ||
             stall_cnt_o !== '0) begin
            failures++;
            $display("FAIL reset cyc%0d hold=%h flush=%h we=%b busy=%b err=%b stall=%0d exp all zero",
                     i, hold_o, flush_o, pc_we_o, busy_o, div_err_o, stall_cnt_o);
         end
         next_cycle();
      end
      rst = 1'b0;
      set_in(0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || hold_o !== 4'h0) begin
         failures++;
         $display("FAIL reset_release busy=%b hold=%h exp 0/0", busy_o, hold_o);
      end
      next_cycle();
   endtask

   task automatic test_jump();
      logic [CW-1:0] s0;
      set_in(0, 0, 0, 1, 0);
      ja = 32'h80;
      @(negedge clk);
      s0 = stall_cnt_o;
      checks++;
      if (pc_we_o !== 1'b1 || pc_new_o !== 32'h80 || flush_o !== 4'h6 || hold_o !== 4'h0) begin
         failures++;
         $display("FAIL jump we=%b new=%h flush=%h hold=%h exp 1/80/6/0", pc_we_o, pc_new_o, flush_o, hold_o);
      end
      next_cycle();
      set_in(0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (pc_we_o !== 1'b0 || pc_new_o !== '0 || flush_o !== 4'h0 || stall_cnt_o !== s0) begin
         failures++;
         $display("FAIL jump_after we=%b new=%h flush=%h stall=%0d exp 0/0/0/%0d",
                  pc_we_o, pc_new_o, flush_o, stall_cnt_o, s0);
      end
      next_cycle();
   endtask

   task automatic test_load_use();
      logic [CW-1:0] s0;
      set_in(0, 0, 0, 0, 1);
      @(negedge clk);
      s0 = stall_cnt_o;
      checks++;
      if (hold_o !== 4'h3 || flush_o !== 4'h4 || pc_we_o !== 1'b0) begin
         failures++;
         $display("FAIL load_use hold=%h flush=%h we=%b exp 3/4/0", hold_o, flush_o, pc_we_o);
      end
      next_cycle();
      set_in(0, 0, 0, 1, 1);
      @(negedge clk);
      checks++;
      if (stall_cnt_o !== s0 + 1'b1) begin
         failures++;
         $display("FAIL load_use_stall got=%0d exp=%0d", stall_cnt_o, s0 + 1'b1);
      end
      checks++;
      if (pc_we_o !== 1'b1 || pc_new_o !== ja || flush_o !== 4'h6 || hold_o !== 4'h0) begin
         failures++;
         $display("FAIL load_use_jump we=%b new=%h flush=%h hold=%h exp 1/%h/6/0",
                  pc_we_o, pc_new_o, flush_o, hold_o, ja);
      end
      next_cycle();
      set_in(0, 0, 0, 0, 0);
   endtask

   task automatic test_divide();
      logic [CW-1:0] s0;
      for (int c = 0; c <= 6; c++) begin
         set_in(0, c == 0, c == 5, c == 2, c == 3);
         @(negedge clk);
         if (c == 0) s0 = stall_cnt_o;
         checks++;
         if (c <= 4) begin
            if (hold_o !== 4'h7 || flush_o !== 4'h8 || busy_o !== (c != 0) || pc_we_o !== 1'b0) begin
               failures++;
               $display("FAIL divide cyc%0d hold=%h flush=%h busy=%b we=%b exp 7/8/%b/0",
                        c, hold_o, flush_o, busy_o, pc_we_o, c != 0);
            end
         end else if (c == 5) begin
            if (hold_o !== 4'h0 || flush_o !== 4'h0 || busy_o !== 1'b1 || div_err_o !== 1'b0) begin
               failures++;
               $display("FAIL divide_done hold=%h flush=%h busy=%b err=%b exp 0/0/1/0",
                        hold_o, flush_o, busy_o, div_err_o);
            end
         end else begin
            if (busy_o !== 1'b0 || stall_cnt_o !== s0 + 8'd5) begin
               failures++;
               $display("FAIL divide_end busy=%b stall=%0d exp 0/%0d", busy_o, stall_cnt_o, s0 + 8'd5);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_timeout();
      for (int c = 0; c <= 9; c++) begin
         set_in(0, c == 0, 0, 0, 0);
         @(negedge clk);
         checks++;
         if (c <= 7) begin
            if (hold_o !== 4'h7 || div_err_o !== 1'b0) begin
               failures++;
               $display("FAIL timeout_wait cyc%0d hold=%h err=%b exp 7/0", c, hold_o, div_err_o);
            end
         end else if (c == 8) begin
            if (div_err_o !== 1'b1 || hold_o !== 4'h0 || flush_o !== 4'h0 || busy_o !== 1'b1) begin
               failures++;
               $display("FAIL timeout_err err=%b hold=%h flush=%h busy=%b exp 1/0/0/1",
                        div_err_o, hold_o, flush_o, busy_o);
            end
         end else begin
            if (div_err_o !== 1'b0 || busy_o !== 1'b0) begin
               failures++;
               $display("FAIL timeout_idle err=%b busy=%b exp 0/0", div_err_o, busy_o);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_bus_wait();
      for (int c = 0; c < 4; c++) begin
         set_in(c < 3, 0, 0, 1, 0);
         @(negedge clk);
         checks++;
         if (c < 3) begin
            if (hold_o !== 4'hF || pc_we_o !== 1'b0 || flush_o !== 4'h0) begin
               failures++;
               $display("FAIL bw_jump cyc%0d hold=%h we=%b flush=%h exp F/0/0", c, hold_o, pc_we_o, flush_o);
            end
         end else if (pc_we_o !== 1'b1 || flush_o !== 4'h6 || hold_o !== 4'h0) begin
            failures++;
            $display("FAIL bw_jump_release we=%b flush=%h hold=%h exp 1/6/0", pc_we_o, flush_o, hold_o);
         end
         next_cycle();
      end
      // Divide start, one plain wait cycle, then done held under bus wait.
      for (int c = 0; c <= 6; c++) begin
         set_in(c >= 2 && c <= 4, c == 0, c >= 2 && c <= 5, 0, 0);
         @(negedge clk);
         checks++;
         if (c >= 2 && c <= 4) begin
            if (hold_o !== 4'hF || busy_o !== 1'b1 || div_err_o !== 1'b0) begin
               failures++;
               $display("FAIL bw_div cyc%0d hold=%h busy=%b err=%b exp F/1/0", c, hold_o, busy_o, div_err_o);
            end
         end else if (c == 5) begin
            if (hold_o !== 4'h0 || flush_o !== 4'h0 || busy_o !== 1'b1) begin
               failures++;
               $display("FAIL bw_div_done hold=%h flush=%h busy=%b exp 0/0/1", hold_o, flush_o, busy_o);
            end
         end else if (c == 6) begin
            if (busy_o !== 1'b0) begin
               failures++;
               $display("FAIL bw_div_idle busy=%b exp 0", busy_o);
            end
         end else if (hold_o !== 4'h7) begin
            failures++;
            $display("FAIL bw_div_stall cyc%0d hold=%h exp 7", c, hold_o);
         end
         next_cycle();
      end
   endtask

   task automatic test_reset_in_div();
      set_in(0, 1, 0, 0, 0);
      next_cycle();
      set_in(0, 0, 0, 0, 0);
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || hold_o !== 4'h0 || div_err_o !== 1'b0) begin
         failures++;
         $display("FAIL rst_in_div busy=%b hold=%h err=%b exp 0/0/0", busy_o, hold_o, div_err_o);
      end
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || div_err_o !== 1'b0 || stall_cnt_o !== '0) begin
         failures++;
         $display("FAIL rst_in_div_after busy=%b err=%b stall=%0d exp 0/0/0", busy_o, div_err_o, stall_cnt_o);
      end
      next_cycle();
   endtask

   task automatic test_saturation();
      set_in(1, 0, 0, 0, 0);
      for (int i = 0; i < SMAX + 5; i++) next_cycle();
      @(negedge clk);
      checks++;
      if (stall_cnt_o !== SMAX[CW-1:0]) begin
         failures++;
         $display("FAIL stall_saturate got=%0d exp=%0d", stall_cnt_o, SMAX);
      end
      set_in(0, 0, 0, 0, 0);
      next_cycle();
   endtask

   task automatic test_random();
      logic [3:0] eh, ef;
      logic       ewe, eerr;
      bit         nd;
      for (int i = 0; i < 2000; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         set_in($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 12,
                $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25);
         @(negedge clk);
         model_comb(eh, ef, ewe, eerr, nd);
         checks++;
         if (hold_o !== eh || flush_o !== ef || pc_we_o !== ewe || div_err_o !== eerr ||
             pc_new_o !== (ewe ? ja : '0) || busy_o !== (!rst && m_div) ||
             stall_cnt_o !== m_stalls[CW-1:0] || (hold_o & flush_o) !== 4'h0) begin
            failures++;
            $display("FAIL random it%0d hold=%h/%h flush=%h/%h we=%b/%b err=%b/%b busy=%b/%b stall=%0d/%0d new=%h",
                     i, hold_o, eh, flush_o, ef, pc_we_o, ewe, div_err_o, eerr,
                     busy_o, !rst && m_div, stall_cnt_o, m_stalls, pc_new_o);
         end
         next_cycle();
      end
      rst = 1'b0;
      set_in(0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0);
      test_reset();
      test_jump();
      test_load_use();
      test_divide();
      test_timeout();
      test_bus_wait();
      test_reset_in_div();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
